// File: rtl/aes_dec_pkg.sv
// Shared types, widths and GF(2^8) helpers for the AES decryption controller slice.
// Pure declarations; no timing or flow control.
package aes_dec_pkg;
   localparam int blk_w_c     = 128;
   localparam int key_idx_w_c = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_LAST,
      ST_DONE
   } dec_state_e;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = x;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction
endpackage

// File: rtl/aes_dec_last_round.sv
// Final AES decryption round: InvShiftRows(InvSubBytes(state)) ^ key, no InvMixColumns.
// Combinational, zero latency; no flow control.
module aes_dec_last_round
   import aes_dec_pkg::*;
(
   input  logic [blk_w_c-1:0] state,
   input  logic [blk_w_c-1:0] key,
   output logic [blk_w_c-1:0] result
);
   logic [blk_w_c-1:0] sub;
   logic [blk_w_c-1:0] shifted;

   inv_sub_bytes u_sub (
      .state  (state),
      .result (sub)
   );

   inv_shift_rows u_shift (
      .state  (sub),
      .result (shifted)
   );

   assign result = shifted ^ key;
endmodule

// File: rtl/inv_shift_rows.sv
// Inverse ShiftRows: row r of the column-major state rotates right by r bytes.
// Combinational wiring, zero latency; no flow control.
module inv_shift_rows
   import aes_dec_pkg::*;
(
   input  logic [blk_w_c-1:0] state,
   output logic [blk_w_c-1:0] result
);
   // Byte k of the block (FIPS order) sits at bits [8*(15-k) +: 8], row k%4, column k/4.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         localparam int dst = 15 - (r + 4*c);
         localparam int src = 15 - (r + 4*((c - r + 4) % 4));
         assign result[8*dst +: 8] = state[8*src +: 8];
      end
   end
endmodule

// File: rtl/inv_sub_bytes.sv
// Inverse S-box on all 16 bytes: inverse affine transform, then field inverse.
// Combinational, zero latency; no flow control.
module inv_sub_bytes
   import aes_dec_pkg::*;
(
   input  logic [blk_w_c-1:0] state,
   output logic [blk_w_c-1:0] result
);
   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] a;
      a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      return gf_inv(a);
   endfunction

   for (genvar b = 0; b < 16; b++) begin : g_byte
      assign result[8*b +: 8] = inv_sbox(state[8*b +: 8]);
   end
endmodule

// File: rtl/aes_dec_ctrl.sv
// AES decryption controller sequencing an external round datapath and key store.
// Latency 2*Nr cycles from accept to v_o; one block in flight, ready_o only in IDLE,
// result held until yumi_i.  AES_DEC_CTRL_PERF_EN adds the blocks_o handshake counter.
module aes_dec_ctrl
   import aes_dec_pkg::*;
#(
   parameter int num_rounds_p = 10
)(
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   v_i,
   input  logic [blk_w_c-1:0]     data_i,
   output logic                   ready_o,
   output logic                   v_o,
   output logic [blk_w_c-1:0]     data_o,
   input  logic                   yumi_i,
   output logic [key_idx_w_c-1:0] key_idx_o,
   input  logic [blk_w_c-1:0]     key_i,
   output logic [blk_w_c-1:0]     rnd_state_o,
   output logic [blk_w_c-1:0]     rnd_key_o,
   input  logic [blk_w_c-1:0]     rnd_state_i
`ifdef AES_DEC_CTRL_PERF_EN
   ,
   output logic [31:0]            blocks_o
`endif
);
   localparam logic [key_idx_w_c-1:0] nr_c = key_idx_w_c'(num_rounds_p);

   dec_state_e             st_r;
   dec_state_e             st_nxt;
   logic [blk_w_c-1:0]     state_r;
   logic [key_idx_w_c-1:0] rnd_r;
   logic [blk_w_c-1:0]     last_rnd;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) st_r <= ST_IDLE;
      else         st_r <= st_nxt;
   end

   always_comb begin
      st_nxt = st_r;
      unique case (st_r)
         ST_IDLE:  if (v_i) st_nxt = ST_ISSUE;
         ST_ISSUE: st_nxt = ST_WAIT;
         ST_WAIT:  st_nxt = (rnd_r == 4'd1) ? ST_LAST : ST_ISSUE;
         ST_LAST:  st_nxt = ST_DONE;
         ST_DONE:  if (yumi_i) st_nxt = ST_IDLE;
         default:  st_nxt = ST_IDLE;
      endcase
   end

   // DONE presents the initial-round key index so the store is primed for the next block.
   always_comb begin
      ready_o   = 1'b0;
      v_o       = 1'b0;
      key_idx_o = nr_c;
      unique case (st_r)
         ST_IDLE:  ready_o   = 1'b1;
         ST_ISSUE: key_idx_o = rnd_r;
         ST_WAIT:  key_idx_o = rnd_r;
         ST_LAST:  key_idx_o = '0;
         ST_DONE:  v_o       = 1'b1;
         default:  key_idx_o = nr_c;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r <= '0;
         rnd_r   <= '0;
      end else begin
         unique case (st_r)
            ST_IDLE: if (v_i) begin
               state_r <= data_i ^ key_i;
               rnd_r   <= nr_c - 4'd1;
            end
            ST_WAIT: begin
               state_r <= rnd_state_i;
               if (rnd_r != 4'd1) rnd_r <= rnd_r - 4'd1;
            end
            ST_LAST: state_r <= last_rnd;
            default: ;
         endcase
      end
   end

   aes_dec_last_round u_last (
      .state  (state_r),
      .key    (key_i),
      .result (last_rnd)
   );

   assign data_o      = state_r;
   assign rnd_state_o = state_r;
   assign rnd_key_o   = key_i;

`ifdef AES_DEC_CTRL_PERF_EN
   logic [31:0] blocks_r;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)            blocks_r <= '0;
      else if (v_o && yumi_i) blocks_r <= blocks_r + 32'd1;
   end

   assign blocks_o = blocks_r;
`endif
endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Bench for aes_dec_ctrl: table-driven AES-128 model supplies the key store, the round datapath
// and expected plaintexts for FIPS-197 C.1 and randomized key/ciphertext blocks.
`timescale 1ns/1ps
module tb_aes_dec_ctrl;
   localparam int NR = 10;
   localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;

   logic         clk = 1'b0;
   logic         reset_i;
   logic         v_i;
   logic [127:0] data_i;
   logic         ready_o;
   logic         v_o;
   logic [127:0] data_o;
   logic         yumi_i;
   logic [3:0]   key_idx_o;
   logic [127:0] key_i;
   logic [127:0] rnd_state_o;
   logic [127:0] rnd_key_o;
   logic [127:0] rnd_state_i;
`ifdef AES_DEC_CTRL_PERF_EN
   logic [31:0]  blocks_o;
`endif

   logic [7:0]   sbox     [256];
   logic [7:0]   inv_sbox [256];
   logic [127:0] rk       [16];
   int           n_tests = 0;
   int           n_fail  = 0;

   always #5 clk = ~clk;

   aes_dec_ctrl #(.num_rounds_p(NR)) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .v_i         (v_i),
      .data_i      (data_i),
      .ready_o     (ready_o),
      .v_o         (v_o),
      .data_o      (data_o),
      .yumi_i      (yumi_i),
      .key_idx_o   (key_idx_o),
      .key_i       (key_i),
      .rnd_state_o (rnd_state_o),
      .rnd_key_o   (rnd_key_o),
      .rnd_state_i (rnd_state_i)
`ifdef AES_DEC_CTRL_PERF_EN
      ,
      .blocks_o    (blocks_o)
`endif
   );

   // ---------------- reference AES model ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00; x = a; y = b;
      while (y != 8'h00) begin
         if (y[0]) p = p ^ x;
         x = xt(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] gb(input logic [127:0] s, input int i);
      return 8'(s >> (120 - 8*i));
   endfunction

   function automatic logic [127:0] pb(input logic [127:0] s, input int i, input logic [7:0] b);
      return (s & ~(128'hff << (120 - 8*i))) | (128'(b) << (120 - 8*i));
   endfunction

   function automatic logic [127:0] inv_shift(input logic [127:0] s);
      logic [127:0] o;
      logic [31:0]  row;
      o = '0;
      for (int r = 0; r < 4; r++) begin
         row = {gb(s, r), gb(s, r+4), gb(s, r+8), gb(s, r+12)};
         row = (row >> (8*r)) | (row << (32 - 8*r));
         for (int c = 0; c < 4; c++) o = pb(o, r + 4*c, 8'(row >> (24 - 8*c)));
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_sub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o = pb(o, i, inv_sbox[gb(s, i)]);
      return o;
   endfunction

   function automatic logic [7:0] mix_coef(input int d);
      case (d & 3)
         0:       return 8'h0e;
         1:       return 8'h0b;
         2:       return 8'h0d;
         default: return 8'h09;
      endcase
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   acc;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ mul(gb(s, 4*c + j), mix_coef(j - r));
            o = pb(o, 4*c + r, acc);
         end
      return o;
   endfunction

   function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k);
      return inv_mix(inv_sub(inv_shift(s)) ^ k);
   endfunction

   function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
      logic [127:0] s;
      s = ct ^ rk[NR];
      for (int r = NR - 1; r >= 1; r--) s = inv_round(s, rk[4'(r)]);
      return inv_sub(inv_shift(s)) ^ rk[0];
   endfunction

   // Forward S-box by walking generator 3 and its inverse, then invert the table.
   task automatic init_tables();
      logic [7:0] p;
      logic [7:0] q;
      logic [7:0] x;
      p = 8'h01; q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox[0] = 8'h63;
      for (int i = 0; i < 256; i++) inv_sbox[sbox[8'(i)]] = 8'(i);
   endtask

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 16; i++) rk[4'(i)] = '0;
      for (int i = 0; i < 4; i++) w[6'(i)] = 32'(key >> (96 - 32*i));
      for (int i = 4; i < 44; i++) begin
         t = w[6'(i-1)];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[6'(i)] = w[6'(i-4)] ^ t;
      end
      for (int r = 0; r <= NR; r++)
         rk[4'(r)] = {w[6'(4*r)], w[6'(4*r+1)], w[6'(4*r+2)], w[6'(4*r+3)]};
   endtask

   // Key store is a combinational lookup; the round datapath answers one cycle later.
   assign key_i = rk[key_idx_o];
   always @(posedge clk) rnd_state_i <= inv_round(rnd_state_o, rnd_key_o);

   // ---------------- checking and stimulus ----------------
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; data_i = '0;
      #1;
      check("rst_ready", ready_o, 1);
      check("rst_vo", v_o, 0);
      check("rst_data", data_o, 0);
      check("rst_rnd_state", rnd_state_o, 0);
      check("rst_key_idx", key_idx_o, NR);
      step();
      step();
      reset_i = 1'b0;
   endtask

   task automatic run_block(input logic [127:0] ct, input logic [127:0] exp, input int hold);
      int guard;
      guard = 0;
      while (!ready_o && guard < 100) begin
         step();
         guard++;
      end
      check("ready_wait", ready_o, 1);
      v_i = 1'b1; data_i = ct; yumi_i = 1'b0;
      check("accept_key_idx", key_idx_o, NR);
      step();
      for (int c = 1; c < 2*NR; c++) begin
         v_i    = 1'($urandom_range(0, 1));
         data_i = {$urandom, $urandom, $urandom, $urandom};
         yumi_i = 1'($urandom_range(0, 1));
         check("busy_ready", ready_o, 0);
         check("busy_vo", v_o, 0);
         check("key_idx", key_idx_o, (c == 2*NR - 1) ? 0 : (NR - 1) - (c - 1) / 2);
         check("rnd_key", rnd_key_o, rk[key_idx_o]);
         step();
      end
      v_i = 1'b0; yumi_i = 1'b0;
      check("vo_latency", v_o, 1);
      check("plaintext", data_o, exp);
      for (int h = 0; h < hold; h++) begin
         v_i    = 1'($urandom_range(0, 1));
         data_i = {$urandom, $urandom, $urandom, $urandom};
         step();
         check("hold_vo", v_o, 1);
         check("hold_data", data_o, exp);
         check("hold_ready", ready_o, 0);
      end
      v_i = 1'b0; yumi_i = 1'b1;
      step();
      yumi_i = 1'b0;
      check("post_ready", ready_o, 1);
      check("post_vo", v_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic         seen_vo;
      logic [127:0] key;
      logic [127:0] ct;

      init_tables();
      expand(KAT_KEY);
      do_reset();

      run_block(KAT_CT, KAT_PT, 0);
      run_block(KAT_CT, KAT_PT, 50);
      run_block(KAT_CT, KAT_PT, 0);
      run_block(KAT_CT, KAT_PT, 0);

      // Reset asserted in cycle 7 of a block.
      v_i = 1'b1; data_i = KAT_CT;
      step();
      v_i = 1'b0;
      repeat (6) step();
      reset_i = 1'b1;
      #1;
      check("midrst_ready", ready_o, 1);
      check("midrst_vo", v_o, 0);
      check("midrst_data", data_o, 0);
      check("midrst_rnd_state", rnd_state_o, 0);
      step();
      reset_i = 1'b0;
      seen_vo = 1'b0;
      repeat (30) begin
         step();
         if (v_o) seen_vo = 1'b1;
      end
      check("midrst_no_vo", seen_vo, 0);
      run_block(KAT_CT, KAT_PT, 1);

      for (int n = 0; n < 8; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         ct  = {$urandom, $urandom, $urandom, $urandom};
         expand(key);
         run_block(ct, ref_decrypt(ct), int'($urandom_range(0, 3)));
      end

`ifdef AES_DEC_CTRL_PERF_EN
      expand(KAT_KEY);
      do_reset();
      check("blocks_reset", blocks_o, 0);
      repeat (3) run_block(KAT_CT, KAT_PT, int'($urandom_range(0, 2)));
      check("blocks_three", blocks_o, 3);
      dut.blocks_r = 32'hffff_ffff;
      run_block(KAT_CT, KAT_PT, 0);
      check("blocks_wrap", blocks_o, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
